// File: rtl/prince_sbox_cms_seq.sv
// Nibble-serial sequencer for the pipelined CMS-masked PRINCE S-box.
// It issues one state nibble per enabled cycle into the S-box. It tracks
// in-flight nibbles with a valid pipe that is LAT enabled cycles deep, and
// steers each result back into the state register in issue order. The block
// carries control only. The pipeline advances only in cycles where fresh
// mask randomness is acknowledged.
module prince_sbox_cms_seq #(
    parameter int N_NIB = 16,
    parameter int LAT   = 2,
    parameter int IDX_W = $clog2(N_NIB)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             rnd_ack_i,
    output logic             rnd_req_o,
    output logic             sb_en_o,
    output logic             issue_o,
    output logic [IDX_W-1:0] nib_sel_o,
    output logic             wr_en_o,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counters are one bit wider than an index so that N_NIB never wraps.
    localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(N_NIB);
    localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(N_NIB - 1);

    state_t           state;
    logic [IDX_W:0]   iss_cnt;
    logic [IDX_W:0]   wr_cnt;
    logic [LAT-1:0]   vld_p;

    logic             run;
    logic             en;
    logic             iss;
    logic             wr;
    logic             last_wr;

    // Enable comes only from FSM state and the randomness handshake, never from data.
    always_comb begin
        run     = (state == RUN);
        en      = run & rnd_ack_i;
        iss     = en & (iss_cnt < CNT_FULL);
        wr      = en & vld_p[LAT-1];
        last_wr = wr & (wr_cnt == CNT_LAST);
    end

    // Output decode: indices are forced to zero outside RUN.
    always_comb begin
        rnd_req_o = run;
        sb_en_o   = en;
        issue_o   = iss;
        wr_en_o   = wr;
        nib_sel_o = run ? iss_cnt[IDX_W-1:0] : '0;
        wr_idx_o  = run ? wr_cnt[IDX_W-1:0]  : '0;
        busy_o    = (state != IDLE);
        done_o    = (state == DONE);
    end

    // FSM, issue/write counters and valid pipe; everything freezes while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            iss_cnt <= '0;
            wr_cnt  <= '0;
            vld_p   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= RUN;
                        iss_cnt <= '0;
                        wr_cnt  <= '0;
                        vld_p   <= '0;
                    end
                end
                RUN: begin
                    if (en) begin
                        iss_cnt <= iss_cnt + (IDX_W+1)'(iss);
                        wr_cnt  <= wr_cnt + (IDX_W+1)'(wr);
                        vld_p   <= (vld_p << 1) | LAT'(iss);
                        if (last_wr) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
